// File: rtl/strobe_gen_pkg.sv
// Shared definitions for the strobe generator.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package strobe_gen_pkg;

  // Controller state encoding
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // A programmed period of 0 is clamped up to this value
  localparam int STROBE_GEN_MIN_PERIOD = 1;

endpackage

// File: rtl/strobe_gen_phase.sv
// Wrapping phase counter: counts 0..period-1 while enabled, flags the last phase.
// Latency: o_tc is combinational from the registered phase.
// Backpressure: none; i_en freezes the count, i_clr forces it to 0.
//
// Ports:
//   i_tick   - clock, rising edge
//   i_reset  - synchronous active-high reset
//   i_clr    - clear phase to 0 (wins over i_en)
//   i_en     - advance phase this edge
//   i_period - latched period, must be >= 1 while enabled
//   o_tc     - phase is at i_period-1 (terminal count)
module strobe_gen_phase #(
  parameter int WIDTH = 16
) (
  input  logic             i_tick,
  input  logic             i_reset,
  input  logic             i_clr,
  input  logic             i_en,
  input  logic [WIDTH-1:0] i_period,
  output logic             o_tc
);

  logic [WIDTH-1:0] r_phase;
  logic             w_tc;

  // The counter never passes period-1, so period = 2^WIDTH-1 cannot overflow
  assign w_tc = (r_phase == (i_period - WIDTH'(1)));
  assign o_tc = w_tc;

  always_ff @(posedge i_tick) begin
    if (i_reset || i_clr) begin
      r_phase <= '0;
    end else if (i_en) begin
      r_phase <= w_tc ? '0 : (r_phase + WIDTH'(1));
    end
  end

endmodule

// File: rtl/strobe_gen.sv
// Programmable periodic strobe generator with start/stop and burst count.
// Latency: first strobe in the cycle after accept edge + period; done one cycle after last strobe.
// Backpressure: none; start honoured only in IDLE, stop honoured in RUN (stop wins over start).
//
// Ports:
//   tick         - clock, rising edge
//   reset        - synchronous active-high reset
//   start        - begin a run (sampled level, IDLE only)
//   stop         - abort a run
//   period       - strobe period in ticks, latched on start (0 -> 1)
//   burst        - strobe count, latched on start (0 -> continuous)
//   strobe       - registered single-cycle pulse
//   busy         - run in progress
//   done         - single-cycle pulse after a finite burst completes
//   strobe_count - strobes emitted this/last run (only with STROBE_GEN_CNT_EN)
//
// Optional feature macro: STROBE_GEN_CNT_EN exposes strobe_count.
module strobe_gen
  import strobe_gen_pkg::*;
#(
  parameter int WIDTH   = 16,
  parameter int BURST_W = 8
) (
  input  logic               tick,
  input  logic               reset,
  input  logic               start,
  input  logic               stop,
  input  logic [WIDTH-1:0]   period,
  input  logic [BURST_W-1:0] burst,
  output logic               strobe,
  output logic               busy,
  output logic               done
`ifdef STROBE_GEN_CNT_EN
  ,
  output logic [BURST_W-1:0] strobe_count
`endif
);

  state_t             r_state;
  state_t             w_state_nxt;
  logic [WIDTH-1:0]   r_period;
  logic [BURST_W-1:0] r_burst;
  logic [BURST_W-1:0] r_cnt;
  logic               r_strobe;
  logic               r_busy;
  logic               r_done;
  logic               w_accept;
  logic               w_issue;
  logic               w_tc;
  logic               w_phase_en;

  assign w_phase_en = (r_state == ST_RUN);

  strobe_gen_phase #(
    .WIDTH(WIDTH)
  ) u_phase (
    .i_tick   (tick),
    .i_reset  (reset),
    .i_clr    (w_accept),
    .i_en     (w_phase_en),
    .i_period (r_period),
    .o_tc     (w_tc)
  );

  // Next-state and per-edge events. ST_DONE is the cycle in which the last
  // strobe is on the output; the done pulse is registered out of it, so busy
  // stays high through the last strobe and drops together with done.
  always_comb begin
    w_state_nxt = r_state;
    w_accept    = 1'b0;
    w_issue     = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (start && !stop) begin
          w_accept    = 1'b1;
          w_state_nxt = ST_RUN;
        end
      end
      ST_RUN: begin
        if (stop) begin
          // Abort: the strobe due on this edge is dropped
          w_state_nxt = ST_IDLE;
        end else if (w_tc) begin
          w_issue = 1'b1;
          if ((r_burst != '0) && (r_cnt == (r_burst - BURST_W'(1)))) begin
            w_state_nxt = ST_DONE;
          end
        end
      end
      ST_DONE: begin
        w_state_nxt = ST_IDLE;
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge tick) begin
    if (reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_ff @(posedge tick) begin
    if (reset) begin
      r_period <= '0;
      r_burst  <= '0;
      r_cnt    <= '0;
      r_strobe <= 1'b0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
    end else begin
      r_strobe <= w_issue;
      r_busy   <= (w_state_nxt != ST_IDLE);
      r_done   <= (r_state == ST_DONE);
      if (w_accept) begin
        r_period <= (period == '0) ? WIDTH'(STROBE_GEN_MIN_PERIOD) : period;
        r_burst  <= burst;
        r_cnt    <= '0;
      end else if (w_issue && (r_cnt != '1)) begin
        // Saturates in continuous mode; a finite burst ends before wrapping
        r_cnt <= r_cnt + BURST_W'(1);
      end
    end
  end

  assign strobe = r_strobe;
  assign busy   = r_busy;
  assign done   = r_done;

`ifdef STROBE_GEN_CNT_EN
  assign strobe_count = r_cnt;
`endif

endmodule

// File: doc/strobe_gen.md
# strobe_gen

Programmable periodic strobe generator: the producing end of the tick/timeout interface whose consumers count tick pulses until a compare value is reached. Divides the system clock by a programmable period and emits single-cycle `strobe` pulses, either continuously or for a fixed burst count. Start/stop control and a `busy`/`done` status handshake let a controller sequence timeouts. Sits between the lab controller FSM and any tick-counting timeout blocks.

## Interface
- `WIDTH`, 16: width of the period counter and the `period` input.
- `BURST_W`, 8: width of the burst count.
- `tick`  in  1: system clock; all logic on the rising edge.
- `reset`  in  1: synchronous, active-high reset.
- `start`  in  1: level-sampled request to begin; honoured only in IDLE.
- `stop`  in  1: abort request; honoured in RUN.
- `period`  in  WIDTH: strobe period in `tick` cycles; latched on accepted start.
- `burst`  in  BURST_W: number of strobes to emit; 0 = continuous. Latched on accepted start.
- `strobe`  out  1: one-cycle pulse, registered.
- `busy`  out  1: high while in RUN.
- `done`  out  1: one-cycle pulse when a finite burst completes.
- `strobe_count`  out  BURST_W: strobes emitted in the current or last run. Present only with `STROBE_GEN_CNT_EN`.

## Operation
- States: IDLE, RUN, DONE.
- IDLE: `busy`=0. On an edge with `start`=1 and `stop`=0:
  - latch `period_q`; 0 is treated as 1.
  - latch `burst_q`.
  - clear the phase counter and the emitted count.
  - go to RUN.
- IDLE with `start`=1 and `stop`=1: stop wins, remain in IDLE.
- RUN: the phase counter increments each edge. When it reaches `period_q`-1 it wraps to 0 and `strobe` is registered high for the next cycle. The emitted count increments on each strobe and saturates at its maximum in continuous mode.
- RUN, finite burst: the edge that issues strobe number `burst_q` also moves to DONE.
- DONE: `done`=1, `busy`=0 for exactly one cycle, then IDLE.
- RUN with `stop`=1:
  - next state IDLE.
  - any strobe that would be issued on that edge is suppressed.
  - no `done` pulse.
- `start` during RUN or DONE is ignored. Changes to `period` or `burst` during a run have no effect.
- Reset values: state IDLE; `strobe`=0, `busy`=0, `done`=0, `strobe_count`=0; counters 0. Reset mid-run aborts immediately, with no `done`. Reset overrides `start` and `stop`.
- Counter arithmetic is unsigned WIDTH bits. `period`=2^WIDTH-1 is legal, and the counter never exceeds `period_q`-1.

## Timing
- Start accepted at edge E0: `busy`=1 from the cycle after E0.
- First `strobe` is high in the cycle after edge E0+P, where P=`period_q`. Subsequent strobes follow every P cycles.
- P=1: `strobe` is high in every RUN cycle from cycle E0+1 onward.
- Finite burst N: `done` is high in the cycle after the last strobe cycle. `busy` drops in that same cycle.
- A new start is accepted at the earliest on the edge ending the `done` cycle, which gives an idle gap of at least one cycle between runs.
- `stop` sampled at edge Es: `busy`=0 and `strobe`=0 from the cycle after Es.

## Configuration
- `STROBE_GEN_CNT_EN` defined:
  - the `strobe_count` port exists.
  - it tracks strobes emitted since the last accepted start and holds its value in IDLE until the next start.
- `STROBE_GEN_CNT_EN` undefined:
  - the port and any logic dedicated to it are removed.
  - an internal count is still kept for burst termination.
  - all other behaviour is identical.

## Structure
- Shared package:
  - the state encoding, with IDLE=2'd0, RUN=2'd1, DONE=2'd2.
  - a `STROBE_GEN_MIN_PERIOD` constant (1), used to clamp `period`=0.
- One natural sub-module, `strobe_gen_phase`: the wrapping phase counter with clear and enable inputs and a terminal-count output. The top holds the FSM, the latches and the burst counter.

## Test plan
- Reset, then `period`=10, `burst`=0, `start` pulse:
  - first strobe exactly 10 cycles after the accept edge, then one every 10 cycles.
  - `busy`=1 throughout, `done` never asserts.
- `period`=3, `burst`=4:
  - 4 strobes spaced 3 cycles apart.
  - `done` high for 1 cycle immediately after the 4th strobe, `busy` low in that same cycle.
  - `strobe_count`=4 afterwards.
- `period`=0 and `period`=1, `burst`=5: strobe high on 5 consecutive cycles, then `done`.
- `stop` asserted on the edge where the 2nd strobe of a `period`=4, `burst`=10 run would issue:
  - that strobe is suppressed and `busy` falls next cycle.
  - no `done`; `strobe_count`=1.
- `start` and `stop` high together in IDLE: remains IDLE. `start` pulsed mid-run with a new `period`: ignored, spacing unchanged.
- `reset` asserted mid-run with `period`=5: all outputs 0 next cycle. A fresh start then behaves as the first scenario.
